// File: rtl/ryu_pkg.sv
// Shared types and screen/sprite geometry for the Ryu sprite blocks.
package ryu_pkg;

  typedef enum logic [1:0] {GROUND, RISE, FALL, LAND} jump_state_t;

  localparam int SPRITE_W = 108;
  localparam int SPRITE_H = 144;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Saturate a signed candidate X into [lo, hi]; never wraps.
  function automatic logic [9:0] sat_x(input logic signed [10:0] v,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
    if (v < $signed({1'b0, lo}))
      return lo;
    else if (v > $signed({1'b0, hi}))
      return hi;
    else
      return v[9:0];
  endfunction

endpackage

// File: rtl/vsync_tick.sv
// One-cycle frame tick on each falling edge of the active-low VGA vsync.
module vsync_tick (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic tick
);

  logic vs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vs_q <= 1'b1;
    else
      vs_q <= vs;
  end

  assign tick = vs_q & ~vs;

endmodule

// File: rtl/ryu_jump_controller.sv
// Ryu sprite origin and jump physics; positions advance once per frame on the vsync tick.
module ryu_jump_controller
  import ryu_pkg::*;
#(
  parameter logic [9:0] X_INIT      = 10'd100,
  parameter logic [9:0] GROUND_Y    = 10'd300,
  parameter logic [9:0] X_MIN       = 10'd0,
  parameter logic [9:0] X_MAX       = 10'd532,
  parameter logic [3:0] WALK_V      = 4'd3,
  parameter logic [5:0] JUMP_V      = 6'd12,
  parameter logic [5:0] GRAVITY     = 6'd1,
  parameter logic [3:0] LAND_FRAMES = 4'd4
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic       jump_req,
  input  logic       left,
  input  logic       right,
  output logic [9:0] RyuX,
  output logic [9:0] RyuY,
  output logic       jump_active,
  output logic       busy
);

  jump_state_t state, state_n;
  logic [9:0] x_q, x_n, y_q, y_n;
  logic signed [6:0] vy, vy_n, vx, vx_n, step, vy_grav;
  logic [3:0] land_cnt, land_cnt_n;
  logic jump_pend, jump_pend_n, tick;
  logic signed [10:0] y_sum;
  logic [9:0] x_walk, x_air;

  vsync_tick u_vsync_tick (
    .clk  (vga_clk),
    .rst  (Reset),
    .vs   (vs),
    .tick (tick)
  );

  always_comb begin
    step = '0;
    if (left && !right)
      step = -$signed({3'b000, WALK_V});
    else if (right && !left)
      step = $signed({3'b000, WALK_V});
  end

  assign x_walk  = sat_x($signed({1'b0, x_q}) + $signed({{4{step[6]}}, step}), X_MIN, X_MAX);
  assign x_air   = sat_x($signed({1'b0, x_q}) + $signed({{4{vx[6]}}, vx}), X_MIN, X_MAX);
  assign y_sum   = $signed({1'b0, y_q}) + $signed({{4{vy[6]}}, vy});
  assign vy_grav = vy + $signed({1'b0, GRAVITY});

  // A request seen in GROUND is held until the next tick; anywhere else it is dropped.
  assign jump_pend_n = (state == GROUND && !tick) ? (jump_pend | jump_req) : 1'b0;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state     <= GROUND;
      x_q       <= X_INIT;
      y_q       <= GROUND_Y;
      vy        <= '0;
      vx        <= '0;
      land_cnt  <= '0;
      jump_pend <= 1'b0;
    end else begin
      jump_pend <= jump_pend_n;
      if (tick) begin
        state    <= state_n;
        x_q      <= x_n;
        y_q      <= y_n;
        vy       <= vy_n;
        vx       <= vx_n;
        land_cnt <= land_cnt_n;
      end
    end
  end

  always_comb begin
    state_n    = state;
    x_n        = x_q;
    y_n        = y_q;
    vy_n       = vy;
    vx_n       = vx;
    land_cnt_n = land_cnt;
    case (state)
      GROUND: begin
        if (jump_pend || jump_req) begin
          vy_n    = -$signed({1'b0, JUMP_V});
          vx_n    = step;
          state_n = RISE;
        end else begin
          x_n = x_walk;
        end
      end
      RISE: begin
        x_n  = x_air;
        y_n  = (y_sum < 0) ? 10'd0 : y_sum[9:0];
        vy_n = vy_grav;
        if (!vy_grav[6])
          state_n = FALL;
      end
      FALL: begin
        x_n = x_air;
        if (y_sum >= $signed({1'b0, GROUND_Y})) begin
          y_n        = GROUND_Y;
          vy_n       = '0;
          vx_n       = '0;
          land_cnt_n = LAND_FRAMES;
          state_n    = (LAND_FRAMES == 4'd0) ? GROUND : LAND;
        end else begin
          y_n  = y_sum[9:0];
          vy_n = vy_grav;
        end
      end
      LAND: begin
        if (land_cnt <= 4'd1)
          state_n = GROUND;
        else
          land_cnt_n = land_cnt - 4'd1;
      end
      default: state_n = GROUND;
    endcase
  end

  always_comb begin
    jump_active = (state == RISE) || (state == FALL);
    busy        = (state != GROUND);
  end

  assign RyuX = x_q;
  assign RyuY = y_q;

endmodule

// File: tb/tb_ryu_jump_controller.sv
// Self-checking bench: constant vector table, corner-case sequences and random frames vs a frame-level model.
module tb_ryu_jump_controller;

  logic       vga_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       vs = 1'b1;
  logic       jump_req = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic [9:0] RyuX, RyuY;
  logic       jump_active, busy;

  int checks = 0;
  int failures = 0;

  ryu_jump_controller dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .vs          (vs),
    .jump_req    (jump_req),
    .left        (left),
    .right       (right),
    .RyuX        (RyuX),
    .RyuY        (RyuY),
    .jump_active (jump_active),
    .busy        (busy)
  );

  always #5 vga_clk = ~vga_clk;

  // Frame-level model: airborne flag + signed velocities; rising vs falling follows sign of vy.
  int m_x, m_y, m_vy, m_vx, m_rec;
  bit m_air, m_pend, m_vsq;

  function automatic int clamp_x(input int v);
    if (v < 0) return 0;
    if (v > 532) return 532;
    return v;
  endfunction

  function automatic int walk(input bit l, input bit r);
    if (l && !r) return -3;
    if (r && !l) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_x = 100; m_y = 300; m_vy = 0; m_vx = 0; m_rec = 0;
    m_air = 0; m_pend = 0; m_vsq = 1;
  endtask

  task automatic model_edge(input bit jr, input bit l, input bit r, input bit vsv);
    bit on_ground, tick, pend_next;
    on_ground = !m_air && (m_rec == 0);
    tick      = m_vsq && !vsv;
    pend_next = (on_ground && !tick) ? (m_pend | jr) : 1'b0;
    if (tick) begin
      if (on_ground) begin
        if (m_pend || jr) begin
          m_air = 1; m_vy = -12; m_vx = walk(l, r);
        end else begin
          m_x = clamp_x(m_x + walk(l, r));
        end
      end else if (m_air) begin
        m_x = clamp_x(m_x + m_vx);
        if (m_vy < 0) begin
          m_y = (m_y + m_vy < 0) ? 0 : m_y + m_vy;
          m_vy = m_vy + 1;
        end else if (m_y + m_vy >= 300) begin
          m_y = 300; m_vy = 0; m_vx = 0; m_air = 0; m_rec = 4;
        end else begin
          m_y = m_y + m_vy;
          m_vy = m_vy + 1;
        end
      end else begin
        m_rec = m_rec - 1;
      end
    end
    m_pend = pend_next;
    m_vsq  = vsv;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("x_model", int'(RyuX), m_x);
    check("y_model", int'(RyuY), m_y);
    check("jump_active_model", int'(jump_active), int'(m_air));
    check("busy_model", int'(busy), int'(m_air || m_rec != 0));
  endtask

  task automatic cyc(input bit jr, input bit l, input bit r, input bit vsv);
    @(negedge vga_clk);
    jump_req = jr; left = l; right = r; vs = vsv;
    @(posedge vga_clk);
    model_edge(jr, l, r, vsv);
    #1;
    check_model();
  endtask

  // One frame: vs falls (tick cycle carries jr), then vs returns high.
  task automatic do_tick(input bit jr, input bit l, input bit r);
    cyc(jr, l, r, 1'b0);
    cyc(1'b0, l, r, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge vga_clk);
    #2;
    Reset = 1'b1; vs = 1'b1; jump_req = 1'b0; left = 1'b0; right = 1'b0;
    #1;
    check("rst_x", int'(RyuX), 100);
    check("rst_y", int'(RyuY), 300);
    check("rst_jump_active", int'(jump_active), 0);
    check("rst_busy", int'(busy), 0);
    model_reset();
    repeat (2) @(negedge vga_clk);
    Reset = 1'b0;
    #1;
    check("post_rst_x", int'(RyuX), 100);
    check("post_rst_y", int'(RyuY), 300);
    check("post_rst_busy", int'(busy), 0);
  endtask

  typedef struct {
    bit jr, l, r;
    int ticks;
    int ex, ey;
    bit eja, ebusy;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{0, 0, 1, 144, 532, 300, 0, 0};
    vecs[1]  = '{0, 0, 1, 56,  532, 300, 0, 0};
    vecs[2]  = '{0, 1, 1, 10,  532, 300, 0, 0};
    vecs[3]  = '{0, 1, 0, 10,  502, 300, 0, 0};
    vecs[4]  = '{0, 0, 0, 5,   502, 300, 0, 0};
    vecs[5]  = '{1, 1, 0, 1,   502, 300, 1, 1};
    vecs[6]  = '{0, 0, 1, 1,   499, 288, 1, 1};
    vecs[7]  = '{0, 0, 0, 11,  466, 222, 1, 1};
    vecs[8]  = '{0, 0, 0, 13,  427, 300, 0, 1};
    vecs[9]  = '{0, 1, 0, 3,   427, 300, 0, 1};
    vecs[10] = '{0, 1, 0, 1,   427, 300, 0, 0};
    vecs[11] = '{0, 1, 0, 1,   424, 300, 0, 0};
    vecs[12] = '{0, 1, 0, 200, 0,   300, 0, 0};
    vecs[13] = '{1, 0, 1, 1,   0,   300, 1, 1};
    vecs[14] = '{0, 0, 0, 12,  36,  222, 1, 1};

    model_reset();
    repeat (3) @(negedge vga_clk);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      for (int t = 0; t < vecs[i].ticks; t++)
        do_tick(vecs[i].jr && (t == 0), vecs[i].l, vecs[i].r);
      check($sformatf("vec%0d_x", i), int'(RyuX), vecs[i].ex);
      check($sformatf("vec%0d_y", i), int'(RyuY), vecs[i].ey);
      check($sformatf("vec%0d_ja", i), int'(jump_active), int'(vecs[i].eja));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].ebusy));
    end

    // Reset in the middle of the fall, then a long vs-low hold gives only one step.
    do_reset();
    do_tick(1, 0, 0);
    repeat (15) do_tick(0, 0, 0);
    check("midfall_ja", int'(jump_active), 1);
    do_reset();
    repeat (1000) cyc(0, 0, 1, 0);
    check("vs_hold_x", int'(RyuX), 103);
    cyc(0, 0, 0, 1);

    // Single-cycle pulse away from a tick, full trajectory, requests in air and recovery ignored.
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    do_tick(0, 0, 0);
    check("takeoff_busy", int'(busy), 1);
    check("takeoff_y", int'(RyuY), 300);
    do_tick(0, 0, 0);
    check("tick1_y", int'(RyuY), 288);
    check("tick1_ja", int'(jump_active), 1);
    for (int t = 2; t <= 5; t++) do_tick(1, 0, 0);
    repeat (7) do_tick(0, 0, 0);
    check("tick12_y", int'(RyuY), 222);
    repeat (13) do_tick(0, 0, 0);
    check("tick25_y", int'(RyuY), 300);
    check("tick25_busy", int'(busy), 1);
    check("tick25_ja", int'(jump_active), 0);
    for (int t = 26; t <= 28; t++) do_tick(1, 0, 0);
    do_tick(0, 0, 0);
    check("tick29_busy", int'(busy), 0);
    repeat (3) do_tick(0, 0, 0);
    check("no_queued_jump", int'(busy), 0);
    cyc(1, 0, 0, 1);
    do_tick(0, 0, 0);
    check("ground_req_jump", int'(busy), 1);
    repeat (29) do_tick(0, 0, 0);
    check("landed_again", int'(busy), 0);

    // Request coinciding with the tick.
    do_tick(1, 0, 0);
    check("same_cycle_busy", int'(busy), 1);
    check("same_cycle_y", int'(RyuY), 300);
    do_tick(0, 0, 0);
    check("same_cycle_next_y", int'(RyuY), 288);
    repeat (28) do_tick(0, 0, 0);

    // Random frames, keys and requests checked every cycle against the model.
    begin
      bit l, r, jr, vsv;
      int run;
      l = 0; r = 0; vsv = 1; run = 0;
      for (int c = 0; c < 12000; c++) begin
        if (run == 0) begin
          vsv = ~vsv;
          run = $urandom_range(1, 4);
        end
        run--;
        if ($urandom_range(0, 19) == 0) l = $urandom_range(0, 1);
        if ($urandom_range(0, 19) == 0) r = $urandom_range(0, 1);
        jr = ($urandom_range(0, 15) == 0);
        cyc(jr, l, r, vsv);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ryu_jump_controller.md
Name: ryu_jump_controller

Overview:
- Produces the RyuX/RyuY sprite origin and the jump-sprite select that the Ryu sprite renderers consume.
- Runs jump physics: fixed launch velocity, per-frame gravity, ground landing and a landing-recovery hold. Horizontal walking is clamped to the screen.
- All position updates happen once per frame, at the falling edge of VGA vsync inside vertical blank, so a sprite never tears mid-frame.
- Sits between keyboard decode and the sprite/priority mux.

Parameters:
- X_INIT, 10'd100, RyuX after reset.
- GROUND_Y, 10'd300, RyuY when standing. Must satisfy GROUND_Y+144 <= 480.
- X_MIN, 10'd0, leftmost RyuX.
- X_MAX, 10'd532, rightmost RyuX (640-108).
- WALK_V, 4'd3, horizontal pixels per frame.
- JUMP_V, 6'd12, launch speed in pixels/frame, applied upward.
- GRAVITY, 6'd1, added to vertical velocity each frame.
- LAND_FRAMES, 4'd4, recovery frames after touchdown.

Ports:
- vga_clk, input, 1, system/pixel clock.
- Reset, input, 1, asynchronous active-high reset.
- vs, input, 1, VGA vsync (active low), synchronous to vga_clk.
- jump_req, input, 1, jump key level or pulse; any width of 1 or more cycles.
- left, input, 1, walk-left key level.
- right, input, 1, walk-right key level.
- RyuX, output, 10, sprite origin X (registered).
- RyuY, output, 10, sprite origin Y (registered).
- jump_active, output, 1, 1 selects the jump sprite (RISE/FALL).
- busy, output, 1, 1 when state is not GROUND.

Behaviour:
- Reset (async, Reset=1):
  - RyuX=X_INIT, RyuY=GROUND_Y.
  - state=GROUND, vy=0, vx=0, land_cnt=0.
  - jump_pend=0, vs_q=1.
  - jump_active=0, busy=0.
- Frame tick:
  - vs_q registers vs every cycle. tick = vs_q & ~vs.
  - Exactly one tick per vs falling edge. vs held low gives no repeat ticks.
  - All state, position and velocity registers update only on the vga_clk edge where tick=1. Outputs therefore change 1 cycle after vs is first sampled low.
- jump_pend:
  - Set on any cycle with jump_req=1 while state=GROUND.
  - Cleared on the tick that consumes it.
  - Forced to 0 in all other states, so no queued jumps during air or recovery.
  - Set and tick in the same cycle counts as pending.
- Horizontal step (GROUND only):
  - left only: X-WALK_V. right only: X+WALK_V. Both or neither: no move.
  - Result is saturated to [X_MIN, X_MAX], never wrapping.
- Vertical arithmetic:
  - vy is 7-bit signed. Next Y is computed in 11-bit signed.
  - If Y+vy < 0, Y=0 (clamp at top).
- States and tick transitions:
  - GROUND:
    - If jump_pend: vy=-JUMP_V, vx latched to the signed walk step from left/right at this tick, go to RISE. X does not move on this tick.
    - Otherwise apply the horizontal step.
  - RISE:
    - Y=Y+vy, X=X+vx (saturated), vy=vy+GRAVITY.
    - If the new vy >= 0, go to FALL.
  - FALL:
    - n=Y+vy. X=X+vx (saturated).
    - If n >= GROUND_Y: Y=GROUND_Y, vy=0, vx=0, land_cnt=LAND_FRAMES, go to LAND (or straight to GROUND if LAND_FRAMES=0).
    - Otherwise Y=n, vy=vy+GRAVITY.
  - LAND:
    - No motion.
    - If land_cnt <= 1, go to GROUND. Otherwise decrement land_cnt.
- Combinational outputs: jump_active=1 in RISE/FALL; busy=1 in any state other than GROUND.
- Mid-operation reset returns immediately to the reset values, regardless of state.
- With defaults:
  - Rise lasts 12 ticks, peak RyuY=222.
  - Fall lasts 13 ticks and lands exactly on 300.
  - Landing recovery is 4 ticks.

Decomposition:
- Package ryu_pkg holds:
  - the jump_state_t enum {GROUND, RISE, FALL, LAND};
  - SPRITE_W=108 and SPRITE_H=144;
  - SCREEN_W=640 and SCREEN_H=480.
- Sub-module vsync_tick (falling-edge detector, vs to tick) is natural and reusable by other per-frame blocks. The rest stays flat.

Test Plan:
- Reset mid-FALL, then release -> RyuX=100, RyuY=300, jump_active=0, busy=0 with no tick needed; vs held low for 1000 cycles gives a single tick.
- jump_req pulsed 1 cycle, then ticks:
  - tick 1 -> RyuY=288, jump_active=1;
  - tick 12 -> RyuY=222, state FALL;
  - tick 25 -> RyuY=300, busy=1, jump_active=0;
  - tick 29 -> busy=0.
- right held, no jump, 200 ticks from X=100 -> RyuX reaches 532 at tick 144 and stays 532; left+right held -> RyuX unchanged.
- right held at jump takeoff, released mid-air -> RyuX +3 every airborne tick (vx latched), no motion during LAND.
- jump_req asserted during RISE and during LAND -> no second jump after landing; asserted 1 cycle after return to GROUND -> jump on the next tick.
- jump_req asserted in the same cycle as a tick in GROUND -> RISE entered on that tick, RyuY=288 on the following tick.
